// File: rtl/idiv_unit.sv
// idiv_unit -- iterative radix-2 restoring divider for execution pipe 2.
//
// Executes one RV32M DIV/DIVU/REM/REMU at a time. The unit raises an early
// CTB wakeup exactly one cycle before the result is presented.
//
// Ports
//   clock, reset_n        clock and asynchronous active-low reset
//   flush                 synchronous kill of the in-flight operation
//   in_valid, in_op       issue strobe and opcode (0 DIV, 1 DIVU, 2 REM, 3 REMU)
//   in_rs1_data           dividend
//   in_rs2_data           divisor
//   in_rd_index           destination physical register
//   in_rd_valid           operation writes a register
//   busy                  unit occupied (feeds the issue queue's ex_busy)
//   ctb_valid             early wakeup pulse
//   ctb_prf_int_index     wakeup tag
//   out_valid, out_data   result strobe and quotient/remainder
//   out_rd_index          destination of the result
//   out_rd_valid          result must be written back
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | free, waiting for in_valid
// CALC    | one restoring step per cycle, count 0..XLEN-1
// SPECIAL | divide-by-zero or signed overflow, result already latched
// DONE    | result presented on out_*

`ifndef PRF_INT_INDEX_SIZE
`define PRF_INT_INDEX_SIZE 7
`endif

module idiv_unit #(
    parameter int XLEN      = 32,
    parameter int PRF_IDX_W = `PRF_INT_INDEX_SIZE
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [1:0]           in_op,
    input  logic [XLEN-1:0]      in_rs1_data,
    input  logic [XLEN-1:0]      in_rs2_data,
    input  logic [PRF_IDX_W-1:0] in_rd_index,
    input  logic                 in_rd_valid,
    output logic                 busy,
    output logic                 ctb_valid,
    output logic [PRF_IDX_W-1:0] ctb_prf_int_index,
    output logic                 out_valid,
    output logic [XLEN-1:0]      out_data,
    output logic [PRF_IDX_W-1:0] out_rd_index,
    output logic                 out_rd_valid
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CALC    = 2'd1,
        S_SPECIAL = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam int                CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]   MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [CNT_W-1:0]       r_cnt;
    logic [XLEN-1:0]        r_quo;
    logic [XLEN-1:0]        r_rem;
    logic [XLEN-1:0]        r_dvsr;
    logic                   r_is_rem;
    logic                   r_neg_q;
    logic                   r_neg_r;
    logic [PRF_IDX_W-1:0]   r_rd_index;
    logic                   r_rd_valid;

    logic                   w_start;
    logic                   w_signed;
    logic                   w_rs1_neg;
    logic                   w_rs2_neg;
    logic                   w_div_zero;
    logic                   w_ovf;
    logic                   w_special;
    logic [XLEN-1:0]        w_rs1_mag;
    logic [XLEN-1:0]        w_rs2_mag;
    logic                   w_last;
    logic [XLEN:0]          w_shift_rem;
    logic [XLEN:0]          w_diff;
    logic                   w_no_borrow;
    logic [XLEN-1:0]        w_quo_fix;
    logic [XLEN-1:0]        w_rem_fix;

    // ---------------- issue decode ----------------
    assign w_start    = (r_state == S_IDLE) & in_valid & ~flush;
    assign w_signed   = ~in_op[0];
    assign w_rs1_neg  = w_signed & in_rs1_data[XLEN-1];
    assign w_rs2_neg  = w_signed & in_rs2_data[XLEN-1];
    assign w_div_zero = (in_rs2_data == '0);
    assign w_ovf      = w_signed & (in_rs1_data == MIN_NEG) & (in_rs2_data == '1);
    assign w_special  = w_div_zero | w_ovf;
    // Two's-complement negation of MIN_NEG yields MIN_NEG, which is the exact
    // unsigned magnitude, so no extra width is needed.
    assign w_rs1_mag  = w_rs1_neg ? (-in_rs1_data) : in_rs1_data;
    assign w_rs2_mag  = w_rs2_neg ? (-in_rs2_data) : in_rs2_data;

    // ---------------- restoring step ----------------
    assign w_last      = (r_cnt == LAST_CNT);
    // The partial remainder is always below the divisor, so one extra bit is
    // enough to hold it after the shift.
    assign w_shift_rem = {r_rem, r_quo[XLEN-1]};
    assign w_diff      = w_shift_rem - {1'b0, r_dvsr};
    assign w_no_borrow = ~w_diff[XLEN];

    // ---------------- FSM ----------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        w_state_nxt = w_special ? S_SPECIAL : S_CALC;
                    end
                end
                S_CALC: begin
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                    end
                end
                S_SPECIAL: w_state_nxt = S_DONE;
                S_DONE:    w_state_nxt = S_IDLE;
                default:   w_state_nxt = S_IDLE;
            endcase
        end
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= '0;
            r_quo      <= '0;
            r_rem      <= '0;
            r_dvsr     <= '0;
            r_is_rem   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_rd_index <= '0;
            r_rd_valid <= 1'b0;
        end else if (w_start) begin
            r_cnt      <= '0;
            r_is_rem   <= in_op[1];
            r_rd_index <= in_rd_index;
            r_rd_valid <= in_rd_valid;
            r_dvsr     <= w_rs2_mag;
            // Special results are final as latched; clearing the sign flags
            // makes them pass through the fixup unchanged.
            r_neg_q    <= w_special ? 1'b0 : (w_rs1_neg ^ w_rs2_neg);
            r_neg_r    <= w_special ? 1'b0 : w_rs1_neg;
            if (w_div_zero) begin
                r_quo <= '1;
                r_rem <= in_rs1_data;
            end else if (w_ovf) begin
                r_quo <= MIN_NEG;
                r_rem <= '0;
            end else begin
                r_quo <= w_rs1_mag;
                r_rem <= '0;
            end
        end else if ((r_state == S_CALC) && !flush) begin
            r_cnt <= r_cnt + 1'b1;
            r_quo <= {r_quo[XLEN-2:0], w_no_borrow};
            r_rem <= w_no_borrow ? w_diff[XLEN-1:0] : w_shift_rem[XLEN-1:0];
        end
    end

    // ---------------- outputs (decodes of registered state) ----------------
    assign w_quo_fix = r_neg_q ? (-r_quo) : r_quo;
    assign w_rem_fix = r_neg_r ? (-r_rem) : r_rem;

    assign busy              = (r_state != S_IDLE);
    assign ctb_valid         = r_rd_valid &
                               (((r_state == S_CALC) & w_last) | (r_state == S_SPECIAL));
    assign ctb_prf_int_index = ctb_valid ? r_rd_index : '0;
    assign out_valid         = (r_state == S_DONE);
    assign out_data          = out_valid ? (r_is_rem ? w_rem_fix : w_quo_fix) : '0;
    assign out_rd_index      = out_valid ? r_rd_index : '0;
    assign out_rd_valid      = out_valid & r_rd_valid;

endmodule

// File: doc/idiv_unit.md
# idiv_unit

Iterative radix-2 integer divider for execution pipe 2 (ALU+IntDiv), placed directly downstream of the integer issue queue and register read. It accepts one RV32M DIV/DIVU/REM/REMU operation at a time and holds `busy` high while it works; `busy` feeds the issue queue's `ex_busy` bit for pipe 2. One cycle before the result is ready, it broadcasts the destination tag on the common tag bus (CTB) so that dependent uops can wake up.

## Interface
Parameters:
- `XLEN`, 32: operand and result width.
- `PRF_IDX_W`, `` `PRF_INT_INDEX_SIZE ``: width of a physical register index.

Ports:
- `clock`: input, 1 bit. The block's single clock.
- `reset_n`: input, 1 bit. Asynchronous, active-low reset.
- `flush`: input, 1 bit. Synchronous kill of the in-flight operation (mispredict or exception).
- `in_valid`: input, 1 bit. An operation is presented this cycle.
- `in_op`: input, 2 bits. 0=DIV, 1=DIVU, 2=REM, 3=REMU.
- `in_rs1_data`: input, XLEN bits. Dividend.
- `in_rs2_data`: input, XLEN bits. Divisor.
- `in_rd_index`: input, PRF_IDX_W bits. Destination physical register.
- `in_rd_valid`: input, 1 bit. The operation writes a register (0 means rd=x0).
- `busy`: output, 1 bit. The unit is occupied. Goes to `ex_busy[2]`.
- `ctb_valid`: output, 1 bit. Early wakeup pulse.
- `ctb_prf_int_index`: output, PRF_IDX_W bits. Tag carried by the wakeup pulse.
- `out_valid`: output, 1 bit. Result is valid this cycle.
- `out_data`: output, XLEN bits. Quotient or remainder.
- `out_rd_index`: output, PRF_IDX_W bits. Destination physical register of the result.
- `out_rd_valid`: output, 1 bit. The result must be written to the register file.

## Operation
- FSM states: IDLE, CALC, SPECIAL, DONE.
- `busy` = (state != IDLE). It is decoded from registered state only, so it is glitch-free.
- IDLE, on `in_valid` and not `flush`:
  - Latch the op, the destination index, `rd_valid`, and the operand signs.
  - Divisor == 0 → SPECIAL. Result: quotient = all ones; remainder = dividend.
  - Signed op with dividend == 0x80000000 and divisor == 0xFFFFFFFF → SPECIAL. Result: quotient = 0x80000000; remainder = 0.
  - Any other operation → CALC with count = 0.
    - For signed ops, load the magnitudes |rs1| and |rs2| as XLEN-bit unsigned values; |0x80000000| = 0x80000000 is exact.
    - For unsigned ops, load the raw operands.
- CALC: one restoring step per cycle.
  - Shift {rem, quo} left by 1, trial-subtract the divisor from the upper part, and set the quotient LSB if the subtraction does not borrow.
  - count increments each cycle. When count == XLEN-1 → DONE.
- SPECIAL: lasts one cycle, then → DONE.
- DONE: `out_valid` = 1. Next state is IDLE.
  - Signed fixup: negate the quotient if the operand signs differ; the remainder takes the sign of the dividend. Special results bypass the fixup.
  - `out_data` is the quotient for DIV/DIVU and the remainder for REM/REMU.
- `ctb_valid` = `latched_rd_valid` & ((CALC & count == XLEN-1) | SPECIAL). `ctb_prf_int_index` = latched destination index. Both are zero whenever `ctb_valid` = 0.
- `out_rd_index` and `out_rd_valid` hold the latched values during DONE and are 0 otherwise. `out_data` is 0 when `out_valid` = 0.
- `in_valid` while `busy` = 1 violates the protocol. The input is ignored and no latched state changes.
- `flush` = 1 in any state:
  - State → IDLE at the next edge, and `out_valid` stays 0 for the killed operation.
  - `flush` takes priority over `in_valid` in the same cycle; that input is dropped.
  - A `ctb_valid` already asserted in the flush cycle is not retracted, because the dependents are flushed by the same event.
- Reset (`reset_n` = 0, at any time, including mid-CALC): state → IDLE, and all registers and outputs → 0 immediately (asynchronously).

## Timing
- Issue edge T0 samples `in_valid`.
- Normal operation:
  - CALC occupies cycles T0+1 .. T0+XLEN (32 cycles).
  - `ctb_valid` is high in cycle T0+32.
  - DONE / `out_valid` is in cycle T0+33.
  - `busy` is high for cycles T0+1 .. T0+33.
  - The next operation is accepted at the T0+34 edge at the earliest. Throughput is 1 operation per 34 cycles.
- Special cases:
  - SPECIAL with `ctb_valid` in cycle T0+1.
  - `out_valid` in cycle T0+2.
  - `busy` is high for cycles T0+1 .. T0+2.
- The wakeup always leads the result by exactly 1 cycle, which matches the one-cycle wakeup-to-issue path.
- The issue queue sees `busy` from cycle T0+1. Its ready/select in cycle T0 therefore may still choose pipe 2, and register read must hold that uop, or the issue side must treat pipe 2 as busy in the issue cycle. For this block, a colliding `in_valid` is a protocol error.
- All outputs are registered state or decodes of registered state. There is no combinational path from input to output.

## Test plan
- DIV 100 / 7, rd=5, rd_valid=1:
  - `ctb_valid` with index 5 at T0+32.
  - `out_valid` at T0+33 with `out_data` = 14.
  - `busy` is high for exactly 33 cycles.
- REM −7 (0xFFFFFFF9) by 2, then DIVU 0xFFFFFFFF by 1, issued back-to-back at the first cycle with `busy` = 0. Expected `out_data` values are 0xFFFFFFFF (−1) and 0xFFFFFFFF. The second operation is accepted at the T0+34 edge.
- Divisor zero:
  - DIV 42/0 → 0xFFFFFFFF; REMU 42/0 → 42.
  - Signed overflow: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
  - All four cases have `out_valid` at T0+2 and `ctb_valid` at T0+1.
- rd_valid = 0 on DIV 9/3: `ctb_valid` is never asserted; `out_valid` = 1 at T0+33 with `out_data` = 3 and `out_rd_valid` = 0.
- `flush` at T0+10 during a DIV:
  - No `ctb_valid` or `out_valid` follows; `busy` = 0 from T0+11.
  - A new op presented with `in_valid` in cycle T0+11 is accepted.
  - An `in_valid` driven together with `flush` is dropped.
  - `in_valid` while `busy` = 1 leaves the result unchanged.
- `reset_n` pulsed low asynchronously mid-CALC (not on a clock edge): `busy`, `out_valid`, and `ctb_valid` drop to 0 immediately, and a DIV issued after release returns the correct result with full latency.
